// File: rtl/sap_ctrl_pkg.sv
// rtl/sap_ctrl_pkg.sv - shared constants and types for the SAP micro sequencer
// Purpose: control-word bit map, opcode encodings, sequencer state type and
//          the fixed fetch-phase control words.
// Ports:   none (package)
package sap_ctrl_pkg;

   localparam int OP_BITS = 4;
   localparam int CW_BITS = 19;

   // Control word bit positions, Cp is the MSB
   localparam int CW_CP    = 18;
   localparam int CW_EP    = 17;
   localparam int CW_LMP   = 16;
   localparam int CW_LMI   = 15;
   localparam int CW_CEI   = 14;
   localparam int CW_CEA   = 13;
   localparam int CW_LI    = 12;
   localparam int CW_EI    = 11;
   localparam int CW_LARAM = 10;
   localparam int CW_LAB   = 9;
   localparam int CW_LAALU = 8;
   localparam int CW_EATMP = 7;
   localparam int CW_SU    = 6;
   localparam int CW_EU    = 5;
   localparam int CW_LBTMP = 4;
   localparam int CW_EBA   = 3;
   localparam int CW_LO    = 2;
   localparam int CW_LTMPA = 1;
   localparam int CW_ETMPB = 0;

   localparam logic [OP_BITS-1:0] OP_NOP  = 4'b0000;
   localparam logic [OP_BITS-1:0] OP_ADD  = 4'b0001;
   localparam logic [OP_BITS-1:0] OP_SUB  = 4'b0010;
   localparam logic [OP_BITS-1:0] OP_XCHG = 4'b0011;
   localparam logic [OP_BITS-1:0] OP_MOV  = 4'b0111;
   localparam logic [OP_BITS-1:0] OP_AND  = 4'b1000;
   localparam logic [OP_BITS-1:0] OP_HLT  = 4'b1110;
   localparam logic [OP_BITS-1:0] OP_OUT  = 4'b1111;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      T1   = 3'd1,
      T2   = 3'd2,
      T3   = 3'd3,
      T4   = 3'd4,
      T5   = 3'd5,
      T6   = 3'd6,
      HALT = 3'd7
   } seq_state_t;

   function automatic logic [CW_BITS-1:0] cw_bit(input int idx);
      return CW_BITS'(1) << idx;
   endfunction

   localparam logic [CW_BITS-1:0] CW_FETCH_T1 = cw_bit(CW_EP) | cw_bit(CW_LMP);
   localparam logic [CW_BITS-1:0] CW_FETCH_T2 = cw_bit(CW_CP);
   localparam logic [CW_BITS-1:0] CW_FETCH_T3 = cw_bit(CW_CEI) | cw_bit(CW_LI);

endpackage

// File: rtl/sap_microcode_rom.sv
// rtl/sap_microcode_rom.sv - combinational execute-phase microcode table
// Purpose: maps (opcode, execute step index) to a control word.
// Ports:   op_i        opcode being executed
//          exec_idx_i  execute step: 0=T4, 1=T5, 2=T6
//          cw_o        control word for that step (0 outside the program)
//          last_o      step is the final microstep of the instruction
//          valid_o     opcode is a defined instruction
module sap_microcode_rom
   import sap_ctrl_pkg::*;
(
   input  logic [OP_BITS-1:0] op_i,
   input  logic [1:0]         exec_idx_i,
   output logic [CW_BITS-1:0] cw_o,
   output logic               last_o,
   output logic               valid_o
);

   always_comb begin
      cw_o    = '0;
      last_o  = 1'b0;
      valid_o = 1'b1;
      case (op_i)
         OP_MOV: begin
            case (exec_idx_i)
               2'd0:    cw_o = cw_bit(CW_LMI) | cw_bit(CW_EI);
               2'd1:    begin cw_o = cw_bit(CW_CEA) | cw_bit(CW_LARAM); last_o = 1'b1; end
               default: ;
            endcase
         end
         OP_XCHG: begin
            case (exec_idx_i)
               2'd0:    cw_o = cw_bit(CW_EATMP) | cw_bit(CW_LTMPA);
               2'd1:    cw_o = cw_bit(CW_LAB) | cw_bit(CW_EBA);
               2'd2:    begin cw_o = cw_bit(CW_LBTMP) | cw_bit(CW_ETMPB); last_o = 1'b1; end
               default: ;
            endcase
         end
         OP_ADD: begin
            case (exec_idx_i)
               2'd0:    cw_o = cw_bit(CW_EU);
               2'd1:    begin cw_o = cw_bit(CW_LAALU); last_o = 1'b1; end
               default: ;
            endcase
         end
         OP_SUB: begin
            case (exec_idx_i)
               2'd0:    cw_o = cw_bit(CW_SU) | cw_bit(CW_EU);
               2'd1:    begin cw_o = cw_bit(CW_SU) | cw_bit(CW_EU) | cw_bit(CW_LAALU); last_o = 1'b1; end
               default: ;
            endcase
         end
         OP_AND: begin
            case (exec_idx_i)
               2'd0:    cw_o = cw_bit(CW_EU);
               2'd1:    begin cw_o = cw_bit(CW_EU) | cw_bit(CW_LAALU); last_o = 1'b1; end
               default: ;
            endcase
         end
         OP_OUT: begin
            if (exec_idx_i == 2'd0) begin
               cw_o   = cw_bit(CW_LO);
               last_o = 1'b1;
            end
         end
         // No execute steps: the sequencer finishes these in T3
         OP_NOP, OP_HLT: last_o = 1'b1;
         default: begin
            valid_o = 1'b0;
            last_o  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/sap_micro_sequencer.sv
// rtl/sap_micro_sequencer.sv - microcoded control sequencer for the SAP datapath
// Purpose: fetch in T1-T3, execute opcode microsteps in T4-T6, run/step/halt control.
// Ports:   clk_i, reset_i        clock, synchronous active-high reset
//          run_i, step_i         free-run level, single-instruction pulse
//          ir_opcode_i           IR opcode field, sampled at the end of T3
//          ctrl_word_o           registered datapath strobes
//          t_state_o             one-hot T1..T6, 0 in IDLE/HALT
//          busy_o, halted_o      status
//          illegal_o             one-cycle pulse after T3 of an undefined opcode
//          instr_count_o         retired instructions (HLT not counted)
module sap_micro_sequencer
   import sap_ctrl_pkg::*;
#(
   parameter int OPW    = OP_BITS,
   parameter int CW_W   = CW_BITS,
   parameter int ICNT_W = 8
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              run_i,
   input  logic              step_i,
   input  logic [OPW-1:0]    ir_opcode_i,
   output logic [CW_W-1:0]   ctrl_word_o,
   output logic [5:0]        t_state_o,
   output logic              busy_o,
   output logic              halted_o,
   output logic              illegal_o,
   output logic [ICNT_W-1:0] instr_count_o
);

   seq_state_t state_q, state_d;
   logic [OPW-1:0]    op_q;
   logic [OPW-1:0]    rom_op;
   logic [1:0]        rom_idx;
   logic [CW_W-1:0]   rom_cw;
   logic              rom_last, rom_valid;
   logic              last_q, last_d;
   logic              retire, illegal_d;
   logic [CW_W-1:0]   cw_d, ctrl_word_q;
   logic [5:0]        t_state_d, t_state_q;
   logic              busy_d, busy_q, halted_d, halted_q, illegal_q;
   logic [ICNT_W-1:0] instr_count_q;

   // The ROM is always addressed with the step being entered, so its word
   // lands in ctrl_word on the same edge the state does.
   sap_microcode_rom u_rom (
      .op_i       (rom_op),
      .exec_idx_i (rom_idx),
      .cw_o       (rom_cw),
      .last_o     (rom_last),
      .valid_o    (rom_valid)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      retire    = 1'b0;
      illegal_d = 1'b0;
      rom_op    = op_q;
      rom_idx   = 2'd0;
      case (state_q)
         IDLE: if (run_i || step_i) state_d = T1;
         T1:   state_d = T2;
         T2:   state_d = T3;
         T3: begin
            // op_q is only written on this edge, so look up the live opcode
            rom_op = ir_opcode_i;
            if (ir_opcode_i == OP_HLT) begin
               state_d = HALT;
            end else if (ir_opcode_i == OP_NOP || !rom_valid) begin
               retire    = 1'b1;
               illegal_d = !rom_valid;
            end else begin
               state_d = T4;
               last_d  = rom_last;
            end
         end
         T4: begin
            rom_idx = 2'd1;
            if (last_q) retire = 1'b1;
            else begin
               state_d = T5;
               last_d  = rom_last;
            end
         end
         T5: begin
            rom_idx = 2'd2;
            if (last_q) retire = 1'b1;
            else begin
               state_d = T6;
               last_d  = rom_last;
            end
         end
         T6:      retire = 1'b1;
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
      // Instruction boundary: run is re-sampled here, a stray step is not
      if (retire) state_d = run_i ? T1 : IDLE;
   end

   always_comb begin
      cw_d      = '0;
      t_state_d = 6'b000000;
      busy_d    = 1'b1;
      halted_d  = 1'b0;
      case (state_d)
         T1:   begin cw_d = CW_FETCH_T1; t_state_d = 6'b000001; end
         T2:   begin cw_d = CW_FETCH_T2; t_state_d = 6'b000010; end
         T3:   begin cw_d = CW_FETCH_T3; t_state_d = 6'b000100; end
         T4:   begin cw_d = rom_cw;      t_state_d = 6'b001000; end
         T5:   begin cw_d = rom_cw;      t_state_d = 6'b010000; end
         T6:   begin cw_d = rom_cw;      t_state_d = 6'b100000; end
         HALT: begin busy_d = 1'b0; halted_d = 1'b1; end
         default: busy_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ctrl_word_q   <= '0;
         t_state_q     <= '0;
         busy_q        <= 1'b0;
         halted_q      <= 1'b0;
         illegal_q     <= 1'b0;
         instr_count_q <= '0;
         op_q          <= '0;
      end else begin
         ctrl_word_q <= cw_d;
         t_state_q   <= t_state_d;
         busy_q      <= busy_d;
         halted_q    <= halted_d;
         illegal_q   <= illegal_d;
         if (state_q == T3) op_q <= ir_opcode_i;
         if (retire) instr_count_q <= instr_count_q + ICNT_W'(1);
      end
   end

   assign ctrl_word_o   = ctrl_word_q;
   assign t_state_o     = t_state_q;
   assign busy_o        = busy_q;
   assign halted_o      = halted_q;
   assign illegal_o     = illegal_q;
   assign instr_count_o = instr_count_q;

endmodule

// File: tb/tb_sap_micro_sequencer.sv
// tb/tb_sap_micro_sequencer.sv - directed vector bench for sap_micro_sequencer
module tb_sap_micro_sequencer;

   logic        clk = 1'b0;
   logic        reset, run, step;
   logic [3:0]  opcode;
   logic [18:0] ctrl_word;
   logic [5:0]  t_state;
   logic        busy, halted, illegal;
   logic [7:0]  instr_count;

   int n_cmp = 0;
   int n_bad = 0;

   sap_micro_sequencer dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .run_i         (run),
      .step_i        (step),
      .ir_opcode_i   (opcode),
      .ctrl_word_o   (ctrl_word),
      .t_state_o     (t_state),
      .busy_o        (busy),
      .halted_o      (halted),
      .illegal_o     (illegal),
      .instr_count_o (instr_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]       op;
      logic [2:0]       len;
      logic             ill;
      logic [5:0][18:0] w;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] op, input logic [2:0] len, input logic ill,
                               input logic [18:0] e4, input logic [18:0] e5, input logic [18:0] e6);
      vec_t v;
      v.op   = op;
      v.len  = len;
      v.ill  = ill;
      v.w[0] = 19'h30000;
      v.w[1] = 19'h40000;
      v.w[2] = 19'h05000;
      v.w[3] = e4;
      v.w[4] = e5;
      v.w[5] = e6;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_idle(input string name);
      chk({name, ".t_state"}, 32'(t_state), 32'h0);
      chk({name, ".ctrl"}, 32'(ctrl_word), 32'h0);
      chk({name, ".busy"}, 32'(busy), 32'h0);
   endtask

   vec_t vecs[8];
   int   exp_cnt;
   int   cyc;

   initial begin
      vecs[0] = mk(4'b0111, 3'd5, 1'b0, 19'h08800, 19'h02400, 19'h0);
      vecs[1] = mk(4'b0011, 3'd6, 1'b0, 19'h00082, 19'h00208, 19'h00011);
      vecs[2] = mk(4'b0001, 3'd5, 1'b0, 19'h00020, 19'h00100, 19'h0);
      vecs[3] = mk(4'b0010, 3'd5, 1'b0, 19'h00060, 19'h00160, 19'h0);
      vecs[4] = mk(4'b1000, 3'd5, 1'b0, 19'h00020, 19'h00120, 19'h0);
      vecs[5] = mk(4'b1111, 3'd4, 1'b0, 19'h00004, 19'h0, 19'h0);
      vecs[6] = mk(4'b0000, 3'd3, 1'b0, 19'h0, 19'h0, 19'h0);
      vecs[7] = mk(4'b0101, 3'd3, 1'b1, 19'h0, 19'h0, 19'h0);

      reset = 1'b1; run = 1'b0; step = 1'b0; opcode = 4'b0000;
      repeat (2) @(negedge clk);
      chk_idle("reset");
      chk("reset.halted", 32'(halted), 32'h0);
      chk("reset.illegal", 32'(illegal), 32'h0);
      chk("reset.count", 32'(instr_count), 32'h0);

      // Free-run through every opcode back to back
      reset = 1'b0; run = 1'b1;
      @(negedge clk);
      exp_cnt = 0;
      foreach (vecs[i]) begin
         opcode = vecs[i].op;
         for (int k = 0; k < int'(vecs[i].len); k++) begin
            chk($sformatf("v%0d.t%0d.t_state", i, k + 1), 32'(t_state), 32'(6'(1) << k));
            chk($sformatf("v%0d.t%0d.ctrl", i, k + 1), 32'(ctrl_word), 32'(vecs[i].w[k]));
            if (k > 0) chk($sformatf("v%0d.t%0d.illegal", i, k + 1), 32'(illegal), 32'h0);
            @(negedge clk);
         end
         exp_cnt++;
         chk($sformatf("v%0d.next_t1", i), 32'(t_state), 32'h1);
         chk($sformatf("v%0d.count", i), 32'(instr_count), 32'(exp_cnt));
         chk($sformatf("v%0d.illegal", i), 32'(illegal), 32'(vecs[i].ill));
      end

      // run drops during T1: the NOP finishes, then the machine parks
      opcode = 4'b0000; run = 1'b0;
      @(negedge clk);
      chk("runfall.t2", 32'(t_state), 32'h2);
      chk("runfall.illegal_width", 32'(illegal), 32'h0);
      @(negedge clk);
      chk("runfall.t3", 32'(t_state), 32'h4);
      @(negedge clk);
      chk_idle("runfall.idle");
      chk("runfall.count", 32'(instr_count), 32'd9);
      @(negedge clk);
      chk_idle("runfall.stay");

      // Single step an ADD; a second pulse during T4 must not start another
      opcode = 4'b0001; step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("step.t%0d.t_state", k + 1), 32'(t_state), 32'(6'(1) << k));
         chk($sformatf("step.t%0d.ctrl", k + 1), 32'(ctrl_word), 32'(vecs[2].w[k]));
         step = (k == 3);
         @(negedge clk);
      end
      step = 1'b0;
      chk_idle("step.idle");
      chk("step.count", 32'(instr_count), 32'd10);
      @(negedge clk);
      chk_idle("step.ignored");

      // Reset in T5 of SUB aborts the instruction
      opcode = 4'b0010; run = 1'b1;
      repeat (5) @(negedge clk);
      chk("abort.t5", 32'(t_state), 32'h10);
      chk("abort.t5ctrl", 32'(ctrl_word), 32'h160);
      reset = 1'b1;
      @(negedge clk);
      chk_idle("abort");
      chk("abort.count", 32'(instr_count), 32'h0);
      chk("abort.illegal", 32'(illegal), 32'h0);
      reset = 1'b0; run = 1'b0;
      @(negedge clk);

      // HLT: sticky until reset
      opcode = 4'b1110; run = 1'b1;
      repeat (3) @(negedge clk);
      chk("hlt.t3", 32'(t_state), 32'h4);
      @(negedge clk);
      chk("hlt.halted", 32'(halted), 32'h1);
      chk_idle("hlt");
      chk("hlt.count", 32'(instr_count), 32'h0);
      for (int k = 0; k < 10; k++) begin
         run  = 1'($urandom_range(0, 1));
         step = 1'($urandom_range(0, 1));
         opcode = 4'($urandom_range(0, 15));
         @(negedge clk);
         chk($sformatf("hlt.hold%0d.halted", k), 32'(halted), 32'h1);
         chk($sformatf("hlt.hold%0d.ctrl", k), 32'(ctrl_word), 32'h0);
      end
      run = 1'b0; step = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("hlt.reset.halted", 32'(halted), 32'h0);
      chk_idle("hlt.reset");
      @(negedge clk);
      chk_idle("hlt.after");

      // Counter wrap after 256 NOPs
      opcode = 4'b0000; run = 1'b1;
      cyc = 0;
      while (instr_count != 8'd255 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      chk("wrap.reach255", 32'(instr_count), 32'd255);
      cyc = 0;
      while (instr_count == 8'd255 && cyc < 6) begin
         @(negedge clk);
         cyc++;
      end
      chk("wrap.zero", 32'(instr_count), 32'd0);
      run = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
